// File: rtl/ir_byte_fetch_seq_pkg.sv
// ir_byte_fetch_seq_pkg
//   Shared definitions for the byte-wide instruction fetch sequencer:
//   FSM state encoding, instruction-register FunSel codes, the reset PC
//   and a program-counter increment helper (modulo 2^16).
package ir_byte_fetch_seq_pkg;

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_LD_LO = 3'd2,
    ST_RD_HI = 3'd3,
    ST_LD_HI = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } fetch_state_e;

  // Instruction register function selects.
  localparam logic [2:0] FS_DEC     = 3'b000;
  localparam logic [2:0] FS_INC     = 3'b001;
  localparam logic [2:0] FS_LOAD    = 3'b010;
  localparam logic [2:0] FS_CLR     = 3'b011;
  localparam logic [2:0] FS_LOAD_LO = 3'b101;
  localparam logic [2:0] FS_LOAD_HI = 3'b110;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  // Byte-address increment; wraps from 16'hFFFF to 16'h0000.
  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// fetch_wait_timer
//   Clearable saturating counter of memory wait cycles.
//   Ports:
//     Clock    in   system clock
//     Reset    in   synchronous active-high reset (count -> 0)
//     Clear    in   force count to 0 (has priority over Tick)
//     Tick     in   count one wait cycle
//     AtLast   out  count is MAX_WAIT-1: one more wait cycle hits the limit
//     Expired  out  count has reached MAX_WAIT
module fetch_wait_timer
  import ir_byte_fetch_seq_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  input  logic Tick,
  output logic AtLast,
  output logic Expired
);

  localparam logic [WAIT_W-1:0] LIMIT  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] LAST   = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] ONE_W  = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] ZERO_W = {WAIT_W{1'b0}};

  logic [WAIT_W-1:0] cnt_r;

  // Wait counter: clear, or count up and saturate at the limit.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_r <= ZERO_W;
    end else if (Clear) begin
      cnt_r <= ZERO_W;
    end else if (Tick && (cnt_r != LIMIT)) begin
      cnt_r <= cnt_r + ONE_W;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Limit flags decoded from the registered count only, so the FSM can use
  // them without forming a combinational loop through Tick.
  always_comb begin
    AtLast  = (cnt_r == LAST);
    Expired = (cnt_r == LIMIT);
  end

endmodule

// File: rtl/ir_byte_fetch_seq.sv
// ir_byte_fetch_seq
//   Fetches one 16-bit instruction from byte-wide memory as two reads (low
//   byte at PC, high byte at PC+1) and loads it into the instruction
//   register through its E/FunSel/I interface. All outputs are registered
//   and decoded from the next state.
//   Ports:
//     Clock, Reset           clock, synchronous active-high reset
//     Start, PCLoad, PCIn    fetch request / PC load (sampled in IDLE only)
//     MemAddr, MemRd         byte read request
//     MemAck, MemData        read completion and data (same cycle)
//     RegE, RegFunSel, RegI  instruction register load interface
//     PC                     program counter
//     Busy, Done, Error      status; Done/Error are one-cycle pulses
module ir_byte_fetch_seq
  import ir_byte_fetch_seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          MAX_WAIT = 15,
  parameter int          WAIT_W   = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        PCLoad,
  input  logic [15:0] PCIn,
  output logic [15:0] MemAddr,
  output logic        MemRd,
  input  logic        MemAck,
  input  logic [7:0]  MemData,
  output logic        RegE,
  output logic [2:0]  RegFunSel,
  output logic [15:0] RegI,
  output logic [15:0] PC,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  fetch_state_e state_r, state_next_s;
  logic [15:0]  pc_r, pc_next_s;
  logic [15:0]  start_pc_r, start_pc_next_s;
  logic [7:0]   byte_r, byte_next_s;

  logic [15:0]  mem_addr_r, mem_addr_next_s;
  logic         mem_rd_r, mem_rd_next_s;
  logic         reg_e_r, reg_e_next_s;
  logic [2:0]   reg_funsel_r, reg_funsel_next_s;
  logic [15:0]  reg_i_r, reg_i_next_s;
  logic         busy_r, busy_next_s;
  logic         done_r, done_next_s;
  logic         error_r, error_next_s;

  logic         wait_tick_s, wait_clr_s, wait_last_s, wait_expired_s;

  fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .Clock   (Clock),
    .Reset   (Reset),
    .Clear   (wait_clr_s),
    .Tick    (wait_tick_s),
    .AtLast  (wait_last_s),
    .Expired (wait_expired_s)
  );

  // Next-state, PC and byte-latch logic.
  always_comb begin
    state_next_s    = state_r;
    pc_next_s       = pc_r;
    start_pc_next_s = start_pc_r;
    byte_next_s     = byte_r;
    wait_tick_s     = 1'b0;
    wait_clr_s      = 1'b1;
    case (state_r)
      ST_IDLE: begin
        // PCLoad wins over Start; a simultaneous Start is dropped.
        if (PCLoad) begin
          pc_next_s = PCIn;
        end else if (Start) begin
          start_pc_next_s = pc_r;
          state_next_s    = ST_RD_LO;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RD_LO, ST_RD_HI: begin
        if (MemAck) begin
          byte_next_s  = MemData;
          pc_next_s    = pc_inc(pc_r);
          state_next_s = (state_r == ST_RD_LO) ? ST_LD_LO : ST_LD_HI;
        end else begin
          wait_tick_s = 1'b1;
          wait_clr_s  = 1'b0;
          // Abort on the wait cycle that brings the count to MAX_WAIT; the
          // PC is restored on entry so the ERR cycle already shows it.
          if (wait_last_s || wait_expired_s) begin
            state_next_s = ST_ERR;
            pc_next_s    = start_pc_r;
          end else begin
            state_next_s = state_r;
          end
        end
      end
      ST_LD_LO: state_next_s = ST_RD_HI;
      ST_LD_HI: state_next_s = ST_DONE;
      ST_DONE:  state_next_s = ST_IDLE;
      ST_ERR:   state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Moore output decode from the next state; FunSel/I/MemAddr hold otherwise.
  always_comb begin
    mem_rd_next_s     = (state_next_s == ST_RD_LO) || (state_next_s == ST_RD_HI);
    reg_e_next_s      = (state_next_s == ST_LD_LO) || (state_next_s == ST_LD_HI);
    busy_next_s       = (state_next_s != ST_IDLE);
    done_next_s       = (state_next_s == ST_DONE);
    error_next_s      = (state_next_s == ST_ERR);
    mem_addr_next_s   = mem_addr_r;
    reg_funsel_next_s = reg_funsel_r;
    reg_i_next_s      = reg_i_r;
    if (mem_rd_next_s) begin
      mem_addr_next_s = pc_next_s;
    end else begin
      mem_addr_next_s = mem_addr_r;
    end
    case (state_next_s)
      ST_LD_LO: begin
        reg_funsel_next_s = FS_LOAD_LO;
        reg_i_next_s      = {8'h00, byte_next_s};
      end
      ST_LD_HI: begin
        reg_funsel_next_s = FS_LOAD_HI;
        reg_i_next_s      = {8'h00, byte_next_s};
      end
      default: begin
        reg_funsel_next_s = reg_funsel_r;
        reg_i_next_s      = reg_i_r;
      end
    endcase
  end

  // Sequencer state, PC, saved start PC and latched read byte.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_PC;
      start_pc_r <= RESET_PC;
      byte_r     <= 8'h00;
    end else begin
      state_r    <= state_next_s;
      pc_r       <= pc_next_s;
      start_pc_r <= start_pc_next_s;
      byte_r     <= byte_next_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mem_addr_r   <= 16'h0000;
      mem_rd_r     <= 1'b0;
      reg_e_r      <= 1'b0;
      reg_funsel_r <= 3'b000;
      reg_i_r      <= 16'h0000;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      mem_addr_r   <= mem_addr_next_s;
      mem_rd_r     <= mem_rd_next_s;
      reg_e_r      <= reg_e_next_s;
      reg_funsel_r <= reg_funsel_next_s;
      reg_i_r      <= reg_i_next_s;
      busy_r       <= busy_next_s;
      done_r       <= done_next_s;
      error_r      <= error_next_s;
    end
  end

  assign MemAddr   = mem_addr_r;
  assign MemRd     = mem_rd_r;
  assign RegE      = reg_e_r;
  assign RegFunSel = reg_funsel_r;
  assign RegI      = reg_i_r;
  assign PC        = pc_r;
  assign Busy      = busy_r;
  assign Done      = done_r;
  assign Error     = error_r;

endmodule

// File: tb/tb_ir_byte_fetch_seq.sv
// tb_ir_byte_fetch_seq
//   Directed bench for ir_byte_fetch_seq. A small memory responder inside
//   run_fetch acks each read after a programmed number of wait cycles, with
//   MemAck driven in the same cycle MemRd is seen. Cycle c=0 is the cycle
//   right after the edge that samples Start.
module tb_ir_byte_fetch_seq;

  logic        Clock = 1'b0;
  logic        Reset, Start, PCLoad, MemAck;
  logic [15:0] PCIn;
  logic [7:0]  MemData;
  logic [15:0] MemAddr, RegI, PC;
  logic        MemRd, RegE, Busy, Done, Error;
  logic [2:0]  RegFunSel;

  int errors = 0;
  int checks = 0;

  // Recorded observations from the last run_fetch call.
  logic [15:0] addr_lo_t, addr_hi_t;
  logic [2:0]  fs_t [2];
  logic [15:0] i_t  [2];
  int          ld_cnt, done_cyc, err_cyc, busy_drop, rd_change;

  ir_byte_fetch_seq dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .PCLoad(PCLoad), .PCIn(PCIn),
    .MemAddr(MemAddr), .MemRd(MemRd), .MemAck(MemAck), .MemData(MemData),
    .RegE(RegE), .RegFunSel(RegFunSel), .RegI(RegI), .PC(PC),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic run_fetch(input int wlo, input int whi, input logic [7:0] blo,
                           input logic [7:0] bhi, input bit poke_hi, input bit rst_hi);
    int          rd_idx = 0;
    int          waits  = 0;
    bit          in_rd  = 1'b0;
    logic [15:0] held   = 16'h0000;
    ld_cnt = 0; done_cyc = -1; err_cyc = -1; busy_drop = 0; rd_change = 0;
    addr_lo_t = 16'hxxxx; addr_hi_t = 16'hxxxx;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (!Busy) busy_drop++;
      if (Done && done_cyc < 0) done_cyc = c;
      if (Error && err_cyc < 0) err_cyc = c;
      if (RegE) begin
        if (ld_cnt < 2) begin
          fs_t[ld_cnt] = RegFunSel;
          i_t[ld_cnt]  = RegI;
        end
        ld_cnt++;
      end
      MemAck = 1'b0; Start = 1'b0; PCLoad = 1'b0;
      if (MemRd) begin
        if (!in_rd) begin
          in_rd = 1'b1; waits = 0; held = MemAddr;
          if (rd_idx == 0) addr_lo_t = MemAddr;
          else addr_hi_t = MemAddr;
        end else if (MemAddr !== held) begin
          rd_change++;
        end
        if (rst_hi && rd_idx == 1) begin
          Reset = 1'b1;
          tick();
          Reset = 1'b0;
          return;
        end
        if (poke_hi && rd_idx == 1) begin
          Start = 1'b1; PCLoad = 1'b1; PCIn = 16'hBEEF;
        end
        if (waits == ((rd_idx == 0) ? wlo : whi)) begin
          MemAck = 1'b1;
          MemData = (rd_idx == 0) ? blo : bhi;
        end else begin
          waits++;
        end
      end else if (in_rd) begin
        in_rd = 1'b0;
        rd_idx++;
      end
      if (done_cyc >= 0 || err_cyc >= 0) break;
      tick();
    end
    MemAck = 1'b0; Start = 1'b0; PCLoad = 1'b0;
  endtask

  task automatic load_pc(input logic [15:0] v);
    PCLoad = 1'b1; PCIn = v;
    tick();
    PCLoad = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; PCLoad = 1'b0; PCIn = 16'h0000;
    MemAck = 1'b0; MemData = 8'h00;
    tick(); tick();
    check_val("rst_pc", PC, 16'h0000);
    check_val("rst_flags", {MemRd, RegE, Busy, Done, Error}, 5'b00000);
    check_val("rst_addr", MemAddr, 16'h0000);
    check_val("rst_ir", {RegFunSel, RegI}, 19'h00000);
    Reset = 1'b0;

    // Zero-wait fetch from 0040: bytes 34 then 12.
    load_pc(16'h0040);
    check_val("pcload", PC, 16'h0040);
    run_fetch(0, 0, 8'h34, 8'h12, 1'b0, 1'b0);
    check_val("t1_addr_lo", addr_lo_t, 16'h0040);
    check_val("t1_addr_hi", addr_hi_t, 16'h0041);
    check_val("t1_ld_cnt", ld_cnt, 2);
    check_val("t1_fs_lo", fs_t[0], 3'b101);
    check_val("t1_i_lo", i_t[0], 16'h0034);
    check_val("t1_fs_hi", fs_t[1], 3'b110);
    check_val("t1_i_hi", i_t[1], 16'h0012);
    check_val("t1_done_cyc", done_cyc, 4);
    check_val("t1_pc", PC, 16'h0042);
    check_val("t1_busy", busy_drop, 0);
    tick();
    check_val("t1_idle", {Busy, Done, RegE}, 3'b000);
    check_val("t1_ir_hold", {RegFunSel, RegI}, {3'b110, 16'h0012});

    // Three wait cycles before each ack.
    run_fetch(3, 3, 8'hA5, 8'h5A, 1'b0, 1'b0);
    check_val("t2_addr_lo", addr_lo_t, 16'h0042);
    check_val("t2_addr_hi", addr_hi_t, 16'h0043);
    check_val("t2_done_cyc", done_cyc, 10);
    check_val("t2_busy", busy_drop, 0);
    check_val("t2_rd_steady", rd_change, 0);
    check_val("t2_i_lo", i_t[0], 16'h00A5);
    check_val("t2_pc", PC, 16'h0044);
    tick();

    // No ack: abort after 15 wait cycles, PC restored.
    load_pc(16'h0100);
    run_fetch(99, 99, 8'h00, 8'h00, 1'b0, 1'b0);
    check_val("t3_err_cyc", err_cyc, 15);
    check_val("t3_no_done", done_cyc, -1);
    check_val("t3_no_rege", ld_cnt, 0);
    check_val("t3_pc", PC, 16'h0100);
    check_val("t3_memrd", MemRd, 1'b0);
    tick();
    check_val("t3_after", {Busy, Error}, 2'b00);

    // PC wrap at FFFF; one wait on the high byte.
    load_pc(16'hFFFF);
    run_fetch(0, 1, 8'h11, 8'h22, 1'b0, 1'b0);
    check_val("t4_addr_lo", addr_lo_t, 16'hFFFF);
    check_val("t4_addr_hi", addr_hi_t, 16'h0000);
    check_val("t4_done_cyc", done_cyc, 5);
    check_val("t4_pc", PC, 16'h0001);
    tick();

    // Start and PCLoad together in IDLE: only the PC load happens.
    Start = 1'b1; PCLoad = 1'b1; PCIn = 16'h0200;
    tick();
    Start = 1'b0; PCLoad = 1'b0;
    check_val("t5_pc", PC, 16'h0200);
    check_val("t5_nofetch", {Busy, MemRd}, 2'b00);
    tick();
    check_val("t5_still_idle", Busy, 1'b0);

    // Start/PCLoad pulsed during RD_HI are ignored.
    run_fetch(0, 2, 8'h77, 8'h88, 1'b1, 1'b0);
    check_val("t6_done_cyc", done_cyc, 6);
    check_val("t6_pc", PC, 16'h0202);
    tick();
    check_val("t6_idle", {Busy, PC}, {1'b0, 16'h0202});

    // Reset asserted in RD_HI.
    run_fetch(0, 3, 8'h99, 8'hAA, 1'b0, 1'b1);
    check_val("t7_ld_cnt", ld_cnt, 1);
    check_val("t7_pc", PC, 16'h0000);
    check_val("t7_flags", {MemRd, RegE, Busy, Done, Error}, 5'b00000);
    check_val("t7_ir", {RegFunSel, RegI}, 19'h00000);
    check_val("t7_addr", MemAddr, 16'h0000);
    tick(); tick();
    check_val("t7_quiet", {RegE, Busy}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
